uart_tx_serial: RTL
===================

# uart_tx_serial

Byte-serial UART transmitter: 8N1 (or 8N2) framing, LSB first, fixed baud from a parameterised divider. Accepts bytes over a valid/ready handshake into a one-entry holding register, so consecutive frames go out back-to-back with no idle bit between them. It sits on the PL output path and drives the USB-UART RX pin. It is the transmit counterpart of the stage's UART receiver.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD` uses truncating integer division (434 at defaults). `CLKS_PER_BIT` must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2. Any other value is a configuration error and is asserted in simulation.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1: upstream has a byte on `tx_data`.
- `tx_ready` out 1: holding register empty. A byte transfers on a rising edge where `tx_valid && tx_ready`.
- `tx_data` in 8: byte to send; sampled only on a handshake edge.
- `tx_serial` out 1: UART line. Idles high.
- `tx_busy` out 1: high while a frame is on the line or a byte is held.

## Operation
- Holding register `hold_data`/`hold_valid`.
  - A handshake sets `hold_valid` and captures `tx_data`.
  - The engine clears `hold_valid` when it loads the byte.
  - `tx_ready = !hold_valid`, registered.
- Engine FSM states: S_IDLE, S_START, S_DATA, S_STOP.
  - **S_IDLE:** `tx_serial` = 1. If `hold_valid`, load the shift register, clear `hold_valid`, zero `clk_cnt` and `bit_idx`, and go to S_START.
  - **S_START:** `tx_serial` = 0 for `CLKS_PER_BIT` cycles, then go to S_DATA.
  - **S_DATA:** `tx_serial` = `shift[bit_idx]`; each bit lasts `CLKS_PER_BIT` cycles. `bit_idx` runs 0..7. After bit 7, go to S_STOP.
  - **S_STOP:** `tx_serial` = 1 for `STOP_BITS × CLKS_PER_BIT` cycles. On the last cycle:
    - if `hold_valid`, load directly and go to S_START, with no idle gap;
    - otherwise go to S_IDLE.
- `clk_cnt` counts 0..`CLKS_PER_BIT`−1 and wraps to 0 on each bit boundary. A separate stop-bit counter handles `STOP_BITS`=2.
- Width rules: `clk_cnt` is `$clog2(CLKS_PER_BIT)` bits; `bit_idx` is 3 bits.
- `tx_serial` is driven from a flop, with no combinational path to the pin.
- `tx_busy = (state != S_IDLE) | hold_valid`, registered.
- Simultaneous load and handshake:
  - `tx_ready` is still 0 in the cycle the engine loads from the holding register. A new byte can be accepted from the following cycle.
  - A held byte is never overwritten.
- `tx_data` and `tx_valid` changes without a handshake have no effect. Dropping `tx_valid` before `tx_ready` is legal; nothing is sent.

## Timing
- Reset values: `tx_serial`=1, `tx_ready`=0 while `rst` is high and 1 from the first cycle after release, `tx_busy`=0.
  - Internally: state S_IDLE, `hold_valid`=0, counters 0.
- Latency: handshake at edge E0 from idle → S_START is loaded at E1 → `tx_serial` goes low after E1. `tx_ready` returns high after E2.
- Frame length: (9 + `STOP_BITS`) × `CLKS_PER_BIT` cycles, which is 10 × 434 = 4340 at defaults.
- Back-to-back frames: the stop bit ends and the next start bit begins on the same edge; the line never idles.
- Throughput: one byte per frame time. `tx_ready` deasserts while one byte is on the line and one is held.
- Reset mid-frame: on the reset edge `tx_serial`=1, the frame is truncated, and the held byte is discarded. The receiver sees a framing error; this is accepted behaviour.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=1_000_000, `BAUD`=100_000, so `CLKS_PER_BIT`=10.
- **Single byte:** one handshake with 0xA5 → `tx_serial` low 1 cycle after the handshake edge. Line bits every 10 cycles are 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). `tx_busy` falls 100 cycles after the start bit begins.
- **Back-to-back:** send 0x00 then 0xFF with `tx_valid` held high → exactly 2 handshakes, 200 contiguous line cycles, no high gap between stop and start.
- **Backpressure:** `tx_valid` held high with 0x11, 0x22, 0x33 → `tx_ready` low for the 3rd byte until the 2nd is loaded. Line order is 0x11, 0x22, 0x33, with no byte lost or duplicated.
- **Two stop bits:** with `STOP_BITS`=2, send 0x3C twice → frames 110 cycles each, stop period 20 cycles high.
- **Reset mid-frame:** assert `rst` for 1 cycle at line bit 4 while a byte is held → `tx_serial`=1 on the next edge and held byte dropped. `tx_ready`=1 afterwards, and a fresh 0x5A then transmits correctly.
- **Loopback:** `tx_serial` into the team's UART receiver at matching parameters, 256 random bytes → every byte received in order with zero mismatches.

Source files
------------

// File: rtl/uart_tx_serial.sv
// uart_tx_serial: 8N1/8N2 UART transmitter with a one-entry holding register
// so that consecutive frames leave back-to-back with no idle bit.
module uart_tx_serial #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115_200,
   parameter int STOP_BITS   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_serial,
   output logic       tx_busy
);
   localparam int CPB = CLK_FREQ_HZ / BAUD;
   localparam int CW  = $clog2(CPB);

   if (CPB < 2) begin : g_bad_baud
      $error("uart_tx_serial: CLK_FREQ_HZ / BAUD must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serial: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state, w_state_n;
   logic [CW-1:0] r_clk_cnt, w_clk_cnt_n;
   logic [2:0]    r_bit_idx, w_bit_idx_n;
   logic          r_stop_cnt, w_stop_cnt_n;
   logic [7:0]    r_shift, w_shift_n, r_hold_data;
   logic          r_hold_valid, w_hold_n;
   logic          r_tx_ready, r_tx_serial, r_tx_busy;
   logic          w_accept, w_last, w_load, w_serial_n;

   assign w_accept  = tx_valid & r_tx_ready;
   assign w_last    = r_clk_cnt == CW'(CPB - 1);
   assign w_hold_n  = w_accept | (r_hold_valid & ~w_load);
   assign tx_ready  = r_tx_ready;
   assign tx_serial = r_tx_serial;
   assign tx_busy   = r_tx_busy;

   always_comb begin
      w_state_n    = r_state;
      w_clk_cnt_n  = w_last ? '0 : r_clk_cnt + 1'b1;
      w_bit_idx_n  = r_bit_idx;
      w_stop_cnt_n = r_stop_cnt;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clk_cnt_n = '0;
            w_load      = r_hold_valid;
         end
         S_START: if (w_last) w_state_n = S_DATA;
         S_DATA: if (w_last) begin
            w_bit_idx_n = r_bit_idx + 1'b1;
            w_state_n   = (r_bit_idx == 3'd7) ? S_STOP : S_DATA;
         end
         S_STOP: if (w_last) begin
            w_stop_cnt_n = 1'b1;
            w_state_n    = (r_stop_cnt == 1'(STOP_BITS - 1)) ? S_IDLE : S_STOP;
            w_load       = (r_stop_cnt == 1'(STOP_BITS - 1)) & r_hold_valid;
         end
         default: w_state_n = S_IDLE;
      endcase
      // a load out of S_STOP skips S_IDLE so the next start bit follows immediately
      if (w_load) begin
         w_state_n    = S_START;
         w_clk_cnt_n  = '0;
         w_bit_idx_n  = '0;
         w_stop_cnt_n = 1'b0;
      end
      w_shift_n  = w_load ? r_hold_data : r_shift;
      w_serial_n = (w_state_n == S_DATA) ? w_shift_n[w_bit_idx_n] : (w_state_n != S_START);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_clk_cnt    <= '0;
         r_bit_idx    <= '0;
         r_stop_cnt   <= 1'b0;
         r_shift      <= '0;
         r_hold_data  <= '0;
         r_hold_valid <= 1'b0;
         r_tx_ready   <= 1'b0;
         r_tx_serial  <= 1'b1;
         r_tx_busy    <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_clk_cnt    <= w_clk_cnt_n;
         r_bit_idx    <= w_bit_idx_n;
         r_stop_cnt   <= w_stop_cnt_n;
         r_shift      <= w_shift_n;
         r_hold_data  <= w_accept ? tx_data : r_hold_data;
         r_hold_valid <= w_hold_n;
         r_tx_ready   <= ~r_hold_valid & ~w_accept;
         r_tx_serial  <= w_serial_n;
         r_tx_busy    <= (w_state_n != S_IDLE) | w_hold_n;
      end
   end
endmodule
